// File: rtl/img_write_ctrl.sv
// Frame write-back sequencer: streams the frame buffer out of the dual-port RAM into
// consecutive SD sectors through the sd_ctrl sector-write handshake.
module img_write_ctrl #(
   parameter logic [31:0] BASE_SEC_ADDR = 32'd20000,
   parameter logic [31:0] SEC_NUM       = 32'd1200,
   parameter logic [8:0]  WORDS_PER_SEC = 9'd256,
   parameter int          RAM_AW        = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              sd_init_done,
   input  logic              wr_busy,
   input  logic              wr_req,
   output logic              wr_start_en,
   output logic [31:0]       wr_sec_addr,
   output logic [15:0]       wr_data,
   output logic              ram_rd_en,
   output logic [RAM_AW-1:0] ram_rd_addr,
   input  logic [15:0]       ram_rd_data,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE, S_PF_RD, S_PF_LD, S_ISSUE, S_WAIT_HI, S_XFER, S_WAIT_LO, S_DONE
   } state_t;

   state_t             state, state_nxt;
   logic [31:0]        sec_cnt;
   logic [RAM_AW-1:0]  word_ptr;
   logic [8:0]         wcnt;
   logic               fetch_pend;
   logic               load_pend;
   logic               req_take;
   logic               last_word;
   logic               sec_last;

   // Only wr_req pulses inside XFER and within the sector's word budget move the pointers.
   assign req_take  = (state == S_XFER) && wr_req && (wcnt < WORDS_PER_SEC);
   assign last_word = (wcnt == WORDS_PER_SEC - 9'd1);
   assign sec_last  = ((sec_cnt + 32'd1) == SEC_NUM);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      case (state)
         S_IDLE:    if (start && sd_init_done) state_nxt = S_PF_RD;
         S_PF_RD:   state_nxt = S_PF_LD;
         S_PF_LD:   state_nxt = S_ISSUE;
         S_ISSUE:   state_nxt = S_WAIT_HI;
         S_WAIT_HI: if (wr_busy) state_nxt = S_XFER;
         S_XFER:    if (req_take && last_word) state_nxt = S_WAIT_LO;
         S_WAIT_LO: if (!wr_busy) state_nxt = sec_last ? S_DONE : S_PF_RD;
         S_DONE:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy        = (state != S_IDLE);
      wr_start_en = (state == S_ISSUE);
      done        = (state == S_DONE);
      ram_rd_en   = (state == S_PF_RD) || fetch_pend;
      ram_rd_addr = ram_rd_en ? word_ptr : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sec_cnt     <= '0;
         word_ptr    <= '0;
         wcnt        <= '0;
         fetch_pend  <= 1'b0;
         load_pend   <= 1'b0;
         wr_data     <= '0;
         wr_sec_addr <= '0;
      end else begin
         // RAM data arrives one cycle after the strobe; capture it then.
         load_pend  <= ram_rd_en;
         fetch_pend <= req_take && !last_word;
         if (load_pend) wr_data <= ram_rd_data;

         if (state == S_IDLE && start && sd_init_done) begin
            sec_cnt  <= '0;
            word_ptr <= '0;
         end
         if (state == S_PF_LD) begin
            wr_sec_addr <= BASE_SEC_ADDR + sec_cnt;
            wcnt        <= '0;
         end
         if (req_take) begin
            wcnt     <= wcnt + 9'd1;
            word_ptr <= word_ptr + RAM_AW'(1);
         end
         if (state == S_WAIT_LO && !wr_busy) sec_cnt <= sec_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_img_write_ctrl.sv
// Bench for img_write_ctrl with a two-sector frame and a RAM whose data equals its address.
module tb_img_write_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        sd_init_done = 1'b0;
   logic        wr_busy = 1'b0;
   logic        wr_req = 1'b0;
   logic        wr_start_en;
   logic [31:0] wr_sec_addr;
   logic [15:0] wr_data;
   logic        ram_rd_en;
   logic [18:0] ram_rd_addr;
   logic [15:0] ram_rd_data;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   img_write_ctrl #(.SEC_NUM(32'd2)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .sd_init_done (sd_init_done),
      .wr_busy      (wr_busy),
      .wr_req       (wr_req),
      .wr_start_en  (wr_start_en),
      .wr_sec_addr  (wr_sec_addr),
      .wr_data      (wr_data),
      .ram_rd_en    (ram_rd_en),
      .ram_rd_addr  (ram_rd_addr),
      .ram_rd_data  (ram_rd_data),
      .busy         (busy),
      .done         (done)
   );

   // RAM model: registered read, data = address
   logic [15:0] ram_q = '0;
   always @(posedge clk) if (ram_rd_en) ram_q <= ram_rd_addr[15:0];
   assign ram_rd_data = ram_q;

   // Event monitor (monotonic counters, sampled mid-cycle)
   int          wse_cnt = 0;
   int          done_cnt = 0;
   int          rd_cnt = 0;
   logic [18:0] last_rd = '0;
   logic        overlap = 1'b0;
   logic        rd_oob = 1'b0;
   always @(negedge clk) begin
      if (wr_start_en) wse_cnt++;
      if (done) done_cnt++;
      if (wr_start_en && done) overlap = 1'b1;
      if (ram_rd_en) begin
         rd_cnt++;
         last_rd = ram_rd_addr;
         if (ram_rd_addr >= 19'd512) rd_oob = 1'b1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " busy"},        32'(busy),        32'd0);
      check({tag, " wr_start_en"}, 32'(wr_start_en), 32'd0);
      check({tag, " done"},        32'(done),        32'd0);
      check({tag, " ram_rd_en"},   32'(ram_rd_en),   32'd0);
      check({tag, " ram_rd_addr"}, 32'(ram_rd_addr), 32'd0);
      check({tag, " wr_sec_addr"}, wr_sec_addr,      32'd0);
      check({tag, " wr_data"},     32'(wr_data),     32'd0);
   endtask

   task automatic wait_issue(input logic [31:0] exp_sec, input string tag);
      int n = 0;
      while (!wr_start_en && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, " issue seen"}, 32'(wr_start_en), 32'd1);
      check({tag, " sec addr"},   wr_sec_addr,      exp_sec);
   endtask

   task automatic enter_xfer();
      wr_busy = 1'b1;
      @(negedge clk);
      @(negedge clk);
   endtask

   // Serve nwords wr_req pulses spaced gap cycles apart, checking each consumed word.
   task automatic serve(input int base, input int nwords, input int gap, input bit poke);
      for (int w = 0; w < nwords; w++) begin
         check($sformatf("word %0d data", base + w), 32'(wr_data), 32'(base + w));
         wr_req = 1'b1;
         @(negedge clk);
         wr_req = 1'b0;
         if (poke && w == 50) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         repeat (gap - 2) @(negedge clk);
      end
      if (nwords == 256) begin
         wr_req = 1'b1;
         @(negedge clk);
         wr_req = 1'b0;
         repeat (4) @(negedge clk);
         check($sformatf("257th req data s%0d", base / 256), 32'(wr_data), 32'(base + 255));
      end
   endtask

   typedef struct {
      logic        start;
      logic        init;
      logic        wbusy;
      logic        req;
      logic        e_busy;
      logic        e_wse;
      logic        e_rd;
      logic [18:0] e_addr;
      logic [31:0] e_sec;
      logic [15:0] e_data;
   } vec_t;

   vec_t vt[8];

   initial begin
      // start ignored without init, then accepted; IDLE..PREFETCH..ISSUE..WAIT_HI..XFER
      vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 19'd0, 32'd0,     16'd0};
      vt[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 19'd0, 32'd0,     16'd0};
      vt[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 19'd0, 32'd0,     16'd0};
      vt[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 19'd0, 32'd0,     16'd0};
      vt[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 19'd0, 32'd20000, 16'd0};
      vt[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 19'd0, 32'd20000, 16'd0};
      vt[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 19'd0, 32'd20000, 16'd0};
      vt[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 19'd0, 32'd20000, 16'd0};

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;
      @(negedge clk);

      // start while the card is not initialised
      start = 1'b1;
      sd_init_done = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("noinit busy", 32'(busy), 32'd0);
      check("noinit rd_en count", 32'(rd_cnt), 32'd0);
      check("noinit wse count", 32'(wse_cnt), 32'd0);

      for (int i = 0; i < 8; i++) begin
         start        = vt[i].start;
         sd_init_done = vt[i].init;
         wr_busy      = vt[i].wbusy;
         wr_req       = vt[i].req;
         @(negedge clk);
         check($sformatf("vec%0d busy", i),        32'(busy),        32'(vt[i].e_busy));
         check($sformatf("vec%0d wr_start_en", i), 32'(wr_start_en), 32'(vt[i].e_wse));
         check($sformatf("vec%0d ram_rd_en", i),   32'(ram_rd_en),   32'(vt[i].e_rd));
         check($sformatf("vec%0d ram_rd_addr", i), 32'(ram_rd_addr), 32'(vt[i].e_addr));
         check($sformatf("vec%0d wr_sec_addr", i), wr_sec_addr,      vt[i].e_sec);
         check($sformatf("vec%0d wr_data", i),     32'(wr_data),     32'(vt[i].e_data));
      end
      start  = 1'b0;
      wr_req = 1'b0;

      // Frame 1 at minimum wr_req spacing, with a stray start mid-sector
      serve(0, 256, 4, 1'b1);
      wr_busy = 1'b0;
      wait_issue(32'd20001, "f1 s1");
      enter_xfer();
      serve(256, 256, 4, 1'b0);
      wr_busy = 1'b0;
      begin
         int n = 0;
         while (!done && n < 40) begin
            @(negedge clk);
            n++;
         end
      end
      check("f1 done seen", 32'(done), 32'd1);
      @(negedge clk);
      check("f1 busy after done", 32'(busy), 32'd0);
      check("f1 done width", 32'(done), 32'd0);
      repeat (3) @(negedge clk);
      check("f1 wr_start_en pulses", 32'(wse_cnt), 32'd2);
      check("f1 done pulses", 32'(done_cnt), 32'd1);
      check("f1 ram reads", 32'(rd_cnt), 32'd512);
      check("f1 last ram addr", 32'(last_rd), 32'd511);
      check("f1 read out of range", 32'(rd_oob), 32'd0);
      check("wr_start_en with done", 32'(overlap), 32'd0);

      // Frame 2, aborted by reset at word 100 of the second sector
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_issue(32'd20000, "f2 s0");
      enter_xfer();
      serve(0, 256, 5, 1'b0);
      wr_busy = 1'b0;
      wait_issue(32'd20001, "f2 s1");
      enter_xfer();
      serve(256, 100, 5, 1'b0);
      #2 rst = 1'b0;
      #1 check_all_zero("midreset");
      @(negedge clk);
      wr_busy = 1'b0;
      rst = 1'b1;
      @(negedge clk);

      // Restart from the base sector and word 0
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_issue(32'd20000, "restart");
      check("restart first data", 32'(wr_data), 32'd0);
      enter_xfer();
      serve(0, 3, 4, 1'b0);
      check("aborted frame no done", 32'(done_cnt), 32'd1);
      check("total wr_start_en pulses", 32'(wse_cnt), 32'd5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors so far %0d", n_errors);
      $fatal(1, "time limit");
   end

endmodule
